dmem_bridge: RTL and testbench
==============================

Name: dmem_bridge

Overview:
- Downstream neighbour of the single-cycle datapath's data port (data_adr / data_out / data_in).
- Converts the core's zero-latency load/store into a req/ack handshake toward a slow data memory.
- Freezes the core through stall while an access is outstanding.
- Flags misaligned and timed-out accesses, and counts stall cycles.

Parameters:
- TIMEOUT, 255: maximum BUSY cycles waiting for mem_ack before aborting; must be >= 1.
- TO_W, 8: width of the timeout counter; must hold TIMEOUT.
- ERR_DATA, 32'hDEADBEEF: load data returned on an aborted or misaligned read.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- mem_read  input  1  core load request; held stable while stall=1.
- mem_write  input  1  core store request; held stable while stall=1.
- data_adr  input  32  byte address from the ALU.
- data_out  input  32  store data from the core.
- data_in  output  32  load data to the core.
- stall  output  1  freezes PC and register-file writes.
- err  output  1  sticky error flag.
- stall_cnt  output  32  saturating count of stall cycles.
- m_req  output  1  memory request.
- m_we  output  1  1 = write.
- m_adr  output  30  word address.
- m_wdata  output  32  write data.
- m_rdata  input  32  read data.
- m_ack  input  1  one-cycle completion pulse.

Behaviour:
- Reset: one clk edge with rst=1 clears all state.
  - state = IDLE; m_req, m_we, err, stall_cnt, timeout counter = 0.
  - m_adr, m_wdata, and the load-data register = 0.
  - Applies from any state, including mid-transaction; m_req is low after that edge, and the memory must drop the aborted access.
- Reset is synchronous and active-high, on one clock named clk with reset named rst.
- States: IDLE, BUSY, DONE (2-bit encoding).
- IDLE:
  - With no request: stall = 0 and data_in = load-data register.
  - Aligned request (data_adr[1:0] == 0, mem_read | mem_write):
    - stall = 1 combinationally, in the same cycle.
    - Capture m_adr = data_adr[31:2], m_wdata = data_out, m_we = mem_write.
    - Set m_req = 1 at the edge; go to BUSY.
  - mem_read and mem_write both high: treated as a write and err set.
  - Misaligned request:
    - stall = 1 for that cycle; no memory transaction, so a store is suppressed.
    - Load-data register = ERR_DATA; err set; go to DONE.
- BUSY:
  - stall = 1; m_req, m_we, m_adr, m_wdata held stable.
  - Timeout counter increments each cycle.
  - m_ack = 1:
    - Load-data register = m_rdata if a read (unchanged on a write).
    - m_req cleared; counter cleared; go to DONE.
  - Counter reaches TIMEOUT with no ack:
    - Load-data register = ERR_DATA; err set; m_req cleared; go to DONE.
  - An ack in the same cycle as the timeout wins; no error.
- DONE:
  - stall = 0 and data_in = load-data register, so the core commits this cycle.
  - Unconditional return to IDLE; a new request is evaluated on the next cycle.
- m_ack in IDLE or DONE is spurious and ignored.
- Minimum latency:
  - 2 stall cycles for a memory access with m_ack in the first BUSY cycle, then DONE.
  - 1 stall cycle for a misaligned access.
- stall_cnt increments on every cycle with stall = 1 and saturates at 32'hFFFFFFFF.
- err is sticky until rst.

Decomposition:
- Shared package holds:
  - state encoding localparams: IDLE=2'd0, BUSY=2'd1, DONE=2'd2;
  - the ERR_DATA default;
  - the word-alignment mask constant.
- Natural sub-module: dmem_timeout_cnt, a loadable up-counter with clear and terminal-count output.
- The rest, FSM plus capture registers, stays in dmem_bridge.

Test Plan:
- Aligned load: data_adr=32'h40, mem_read=1; memory acks the 3rd BUSY cycle with m_rdata=32'h12345678.
  - Expect m_adr=30'h10; stall high 4 cycles.
  - DONE data_in=32'h12345678, stall=0; stall_cnt=4; err=0.
- Store: data_adr=32'h80, data_out=32'hCAFEF00D, mem_write=1, immediate ack.
  - Expect m_we=1, m_adr=30'h20, m_wdata=32'hCAFEF00D; stall 2 cycles; no change to data_in.
- Misaligned load at 32'h42: no m_req ever asserted.
  - Expect 1 stall cycle; DONE data_in=32'hDEADBEEF; err=1, persisting.
- Timeout with TIMEOUT=4 and no ack:
  - Expect m_req high 4 cycles, then dropped; data_in=ERR_DATA; err=1.
  - Repeat with the ack landing exactly on the 4th cycle: expect real data and err=0.
- rst asserted during BUSY:
  - Expect m_req=0, stall=0, stall_cnt=0, err=0 after that edge.
  - A new load afterwards completes normally.
  - A spurious m_ack in IDLE causes no state change.

Source files
------------

// File: rtl/dmem_bridge_pkg.sv
// Shared types and constants for the data-memory bridge.
package dmem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [31:0] ERR_DATA_DEF    = 32'hDEADBEEF;
  localparam logic [1:0]  WORD_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/dmem_timeout_cnt.sv
// Loadable up-counter with clear; the terminal count flags the TC-th counted cycle.
module dmem_timeout_cnt #(
  parameter int unsigned W  = 8,
  parameter int unsigned TC = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_tc_c
);

  logic [W-1:0] r_cnt;

  // The count holds at the terminal value instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && !o_tc_c) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_tc_c = (r_cnt == W'(TC - 1));

endmodule

// File: rtl/dmem_bridge.sv
// Turns the core's zero-latency load/store into a req/ack memory access,
// stalling the core while the access is outstanding.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned TO_W     = 8,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] data_adr,
  input  logic [31:0] data_out,
  output logic [31:0] data_in,
  output logic        stall,
  output logic        err,
  output logic [31:0] stall_cnt,
  output logic        m_req,
  output logic        m_we,
  output logic [29:0] m_adr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack
);

  state_e      r_state;
  state_e      w_next;
  logic        w_req;
  logic        w_misalign;
  logic        w_accept;
  logic        w_misacc;
  logic        w_ack;
  logic        w_timeout;
  logic        w_tc;

  logic        r_req;
  logic        r_we;
  logic [29:0] r_adr;
  logic [31:0] r_wdata;
  logic [31:0] r_ldata;
  logic        r_err;
  logic [31:0] r_stall_cnt;

  assign w_req      = mem_read | mem_write;
  assign w_misalign = (data_adr[1:0] & WORD_ALIGN_MASK) != 2'b00;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Stall must rise in the request cycle itself, so it is decoded combinationally.
  always_comb begin
    w_next    = r_state;
    stall     = 1'b0;
    w_accept  = 1'b0;
    w_misacc  = 1'b0;
    w_ack     = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          stall = 1'b1;
          if (w_misalign) begin
            w_misacc = 1'b1;
            w_next   = DONE;
          end else begin
            w_accept = 1'b1;
            w_next   = BUSY;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (m_ack) begin
          w_ack  = 1'b1;
          w_next = DONE;
        end else if (w_tc) begin
          w_timeout = 1'b1;
          w_next    = DONE;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  dmem_timeout_cnt #(
    .W  (TO_W),
    .TC (TIMEOUT)
  ) u_timeout_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_ack | w_timeout),
    .i_load     (w_accept),
    .i_load_val ('0),
    .i_en       (r_state == BUSY),
    .o_tc_c     (w_tc)
  );

  // Request capture, load-data return, sticky error and stall accounting.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= '0;
      r_wdata     <= '0;
      r_ldata     <= '0;
      r_err       <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_req   <= 1'b1;
        r_we    <= mem_write;
        r_adr   <= data_adr[31:2];
        r_wdata <= data_out;
        if (mem_read && mem_write) begin
          r_err <= 1'b1;
        end
      end
      if (w_misacc) begin
        r_ldata <= ERR_DATA;
        r_err   <= 1'b1;
      end
      if (w_ack) begin
        r_req <= 1'b0;
        if (!r_we) begin
          r_ldata <= m_rdata;
        end
      end
      if (w_timeout) begin
        r_req   <= 1'b0;
        r_ldata <= ERR_DATA;
        r_err   <= 1'b1;
      end
      if (stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign data_in   = r_ldata;
  assign err       = r_err;
  assign stall_cnt = r_stall_cnt;
  assign m_req     = r_req;
  assign m_we      = r_we;
  assign m_adr     = r_adr;
  assign m_wdata   = r_wdata;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed test of dmem_bridge with hand-computed expectations (TIMEOUT = 4).
module tb_dmem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] data_adr;
  logic [31:0] data_out;
  logic [31:0] data_in;
  logic        stall;
  logic        err;
  logic [31:0] stall_cnt;
  logic        m_req;
  logic        m_we;
  logic [29:0] m_adr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ack;

  int n_chk  = 0;
  int n_fail = 0;
  int req_cycles;

  always #5 clk = ~clk;

  dmem_bridge #(
    .TIMEOUT  (4),
    .TO_W     (8),
    .ERR_DATA (32'hDEADBEEF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .data_adr  (data_adr),
    .data_out  (data_out),
    .data_in   (data_in),
    .stall     (stall),
    .err       (err),
    .stall_cnt (stall_cnt),
    .m_req     (m_req),
    .m_we      (m_we),
    .m_adr     (m_adr),
    .m_wdata   (m_wdata),
    .m_rdata   (m_rdata),
    .m_ack     (m_ack)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven 1ns after the edge, outputs checked 1ns later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    m_ack     = 1'b0;
    cyc();
    rst = 1'b0;
    settle();
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    data_adr  = '0;
    data_out  = '0;
    m_rdata   = '0;
    m_ack     = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
    settle();
    check("rst_m_req",     32'(m_req), 32'd0);
    check("rst_stall",     32'(stall), 32'd0);
    check("rst_stall_cnt", stall_cnt,  32'd0);
    check("rst_err",       32'(err),   32'd0);
    check("rst_data_in",   data_in,    32'd0);
    check("rst_m_adr",     32'(m_adr), 32'd0);

    // Aligned load, acked in the third BUSY cycle.
    mem_read = 1'b1; data_adr = 32'h40;
    settle();
    check("ld_idle_stall", 32'(stall), 32'd1);
    check("ld_idle_mreq",  32'(m_req), 32'd0);
    cyc();
    check("ld_b1_mreq",  32'(m_req), 32'd1);
    check("ld_b1_madr",  32'(m_adr), 32'h10);
    check("ld_b1_mwe",   32'(m_we),  32'd0);
    check("ld_b1_stall", 32'(stall), 32'd1);
    cyc();
    check("ld_b2_stall", 32'(stall), 32'd1);
    cyc();
    m_ack = 1'b1; m_rdata = 32'h12345678;
    settle();
    check("ld_b3_stall", 32'(stall), 32'd1);
    cyc();
    m_ack = 1'b0;
    settle();
    check("ld_done_stall", 32'(stall), 32'd0);
    check("ld_done_data",  data_in,    32'h12345678);
    check("ld_done_scnt",  stall_cnt,  32'd4);
    check("ld_done_err",   32'(err),   32'd0);
    check("ld_done_mreq",  32'(m_req), 32'd0);
    mem_read = 1'b0;
    cyc();
    check("ld_idle2_stall", 32'(stall), 32'd0);

    // Store with immediate ack.
    mem_write = 1'b1; data_adr = 32'h80; data_out = 32'hCAFEF00D;
    settle();
    check("st_idle_stall", 32'(stall), 32'd1);
    cyc();
    check("st_b1_mwe",    32'(m_we),  32'd1);
    check("st_b1_madr",   32'(m_adr), 32'h20);
    check("st_b1_mwdata", m_wdata,    32'hCAFEF00D);
    check("st_b1_mreq",   32'(m_req), 32'd1);
    m_ack = 1'b1; m_rdata = 32'h55555555;
    settle();
    check("st_b1_stall", 32'(stall), 32'd1);
    cyc();
    m_ack = 1'b0; mem_write = 1'b0;
    settle();
    check("st_done_stall", 32'(stall), 32'd0);
    check("st_done_data",  data_in,    32'h12345678);
    check("st_done_scnt",  stall_cnt,  32'd6);
    cyc();

    // Misaligned load: one stall cycle and no memory request.
    mem_read = 1'b1; data_adr = 32'h42;
    settle();
    check("mis_idle_stall", 32'(stall), 32'd1);
    check("mis_idle_mreq",  32'(m_req), 32'd0);
    cyc();
    check("mis_done_mreq",  32'(m_req), 32'd0);
    check("mis_done_stall", 32'(stall), 32'd0);
    check("mis_done_data",  data_in,    32'hDEADBEEF);
    check("mis_done_err",   32'(err),   32'd1);
    check("mis_done_scnt",  stall_cnt,  32'd7);
    mem_read = 1'b0;
    cyc();
    check("mis_err_sticky", 32'(err),   32'd1);
    check("mis_idle2_mreq", 32'(m_req), 32'd0);

    // Timeout: no ack, m_req must stay high exactly 4 cycles.
    do_reset();
    mem_read = 1'b1; data_adr = 32'h100;
    settle();
    req_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (m_req) req_cycles++;
      else break;
    end
    check("to_req_cycles", 32'(req_cycles), 32'd4);
    check("to_done_stall", 32'(stall),      32'd0);
    check("to_done_data",  data_in,         32'hDEADBEEF);
    check("to_done_err",   32'(err),        32'd1);
    check("to_done_scnt",  stall_cnt,       32'd5);
    mem_read = 1'b0;
    cyc();

    // Ack coinciding with the timeout cycle wins.
    do_reset();
    mem_read = 1'b1; data_adr = 32'h104;
    cyc();
    cyc();
    cyc();
    cyc();
    check("toa_b4_mreq", 32'(m_req), 32'd1);
    m_ack = 1'b1; m_rdata = 32'hA5A50F0F;
    cyc();
    m_ack = 1'b0;
    settle();
    check("toa_done_data", data_in,    32'hA5A50F0F);
    check("toa_done_err",  32'(err),   32'd0);
    check("toa_done_mreq", 32'(m_req), 32'd0);
    check("toa_done_scnt", stall_cnt,  32'd5);
    mem_read = 1'b0;
    cyc();

    // Reset in the middle of BUSY, after err has been set.
    mem_read = 1'b1; data_adr = 32'h3;
    cyc();
    mem_read = 1'b0;
    cyc();
    check("rb_err_pre", 32'(err), 32'd1);
    mem_read = 1'b1; data_adr = 32'h200;
    cyc();
    check("rb_b1_mreq", 32'(m_req), 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0; mem_read = 1'b0;
    settle();
    check("rb_mreq",  32'(m_req), 32'd0);
    check("rb_stall", 32'(stall), 32'd0);
    check("rb_scnt",  stall_cnt,  32'd0);
    check("rb_err",   32'(err),   32'd0);

    // A new load after the aborted one completes normally.
    cyc();
    mem_read = 1'b1; data_adr = 32'h300;
    cyc();
    check("nl_b1_madr", 32'(m_adr), 32'hC0);
    m_ack = 1'b1; m_rdata = 32'h0BADF00D;
    cyc();
    m_ack = 1'b0; mem_read = 1'b0;
    settle();
    check("nl_done_data", data_in,   32'h0BADF00D);
    check("nl_done_scnt", stall_cnt, 32'd2);
    cyc();

    // Spurious ack in IDLE is ignored.
    m_ack = 1'b1; m_rdata = 32'hFFFF0000;
    cyc();
    m_ack = 1'b0;
    settle();
    check("sp_mreq",  32'(m_req), 32'd0);
    check("sp_stall", 32'(stall), 32'd0);
    check("sp_data",  data_in,    32'h0BADF00D);
    check("sp_scnt",  stall_cnt,  32'd2);
    check("sp_err",   32'(err),   32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
